// File: rtl/ir_cmd_scheduler_if.sv
// Bundle of IR input, manual request and command-output signals for ir_cmd_scheduler.
// The master side drives stimulus and consumes commands; the slave side is the scheduler.
interface ir_cmd_scheduler_if #(
    parameter int unsigned Depth = 4
);
    localparam int unsigned LvlW = $clog2(Depth) + 1;

    logic            ir_valid;
    logic [31:0]     ir_data;
    logic            man_req;
    logic [7:0]      man_key;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [7:0]      cmd_key;
    logic            cmd_src;
    logic [3:0]      cmd_button;
    logic            mute;
    logic [LvlW-1:0] fifo_level;
    logic [7:0]      drop_count;

    modport master (
        output ir_valid, ir_data, man_req, man_key, cmd_ready,
        input  cmd_valid, cmd_key, cmd_src, cmd_button, mute, fifo_level, drop_count
    );

    modport slave (
        input  ir_valid, ir_data, man_req, man_key, cmd_ready,
        output cmd_valid, cmd_key, cmd_src, cmd_button, mute, fifo_level, drop_count
    );
endinterface

// File: rtl/ir_cmd_scheduler.sv
// Validates IR frames, suppresses held-key auto-repeat, arbitrates against manual requests
// and queues accepted commands in a first-word-fall-through FIFO; also tracks mute and drops.
module ir_cmd_scheduler #(
    parameter int unsigned Depth         = 4,
    parameter int unsigned HoldoffCycles = 25000000,
    parameter logic [15:0] CustomCode    = 16'h0000,
    parameter bit          CheckCustom   = 1'b0,
    parameter logic [7:0]  MuteKey       = 8'h0C
) (
    input logic               clk_i,
    input logic               rst_ni,
    ir_cmd_scheduler_if.slave bus_io
);
    localparam int unsigned PtrW  = $clog2(Depth);
    localparam int unsigned LvlW  = PtrW + 1;
    localparam int unsigned HoldW = (HoldoffCycles > 0) ? $clog2(HoldoffCycles + 1) : 1;

    typedef enum logic [1:0] {StIdle, StCheck, StPend} ir_state_e;

    ir_state_e        state_q, state_d;
    logic             ir_prev_q;
    logic [31:0]      frame_q, frame_d;
    logic [7:0]       last_key_q, last_key_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             mute_q, mute_d;
    logic [7:0]       drop_q, drop_d;
    logic [8:0]       mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]  count_q;

    logic       new_frame, frame_ok, full, valid, pop, room;
    logic       man_push, ir_push, push, ir_drop, man_drop;
    logic [8:0] push_data, head, drop_sum;

    assign new_frame = bus_io.ir_valid & ~ir_prev_q;
    assign frame_ok  = (frame_q[31:24] == ~frame_q[23:16]) &&
                       (!CheckCustom || (frame_q[15:0] == CustomCode));
    assign valid     = (count_q != '0);
    assign full      = (count_q == LvlW'(Depth));
    assign pop       = valid & bus_io.cmd_ready;
    assign room      = ~full | pop;
    assign man_push  = bus_io.man_req & room;
    assign man_drop  = bus_io.man_req & ~room;
    assign ir_drop   = new_frame & (state_q != StIdle);

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        last_key_d = last_key_q;
        hold_d     = (hold_q != '0) ? hold_q - HoldW'(1) : '0;
        ir_push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (new_frame) begin
                    frame_d = bus_io.ir_data;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (!frame_ok) begin
                    state_d = StIdle;
                end else if ((frame_q[23:16] == last_key_q) && (hold_q != '0)) begin
                    // Held key: restart the window so a continuous hold stays suppressed.
                    hold_d  = HoldW'(HoldoffCycles);
                    state_d = StIdle;
                end else begin
                    state_d = StPend;
                end
            end
            StPend: begin
                if (room && !man_push) begin
                    ir_push    = 1'b1;
                    last_key_d = frame_q[23:16];
                    hold_d     = HoldW'(HoldoffCycles);
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign push      = man_push | ir_push;
    assign push_data = man_push ? {1'b1, bus_io.man_key} : {1'b0, frame_q[23:16]};
    assign mute_d    = mute_q ^ (push && (push_data[7:0] == MuteKey));
    assign drop_sum  = {1'b0, drop_q} + {8'd0, ir_drop} + {8'd0, man_drop};
    assign drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            ir_prev_q  <= 1'b0;
            frame_q    <= '0;
            last_key_q <= '0;
            hold_q     <= '0;
            mute_q     <= 1'b0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ir_prev_q  <= bus_io.ir_valid;
            frame_q    <= frame_d;
            last_key_q <= last_key_d;
            hold_q     <= hold_d;
            mute_q     <= mute_d;
            drop_q     <= drop_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q    <= count_q + LvlW'(push) - LvlW'(pop);
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head                = mem_q[rd_ptr_q];
    assign bus_io.cmd_valid    = valid;
    assign bus_io.cmd_key      = valid ? head[7:0] : 8'h00;
    assign bus_io.cmd_src      = valid & head[8];
    assign bus_io.mute         = mute_q;
    assign bus_io.fifo_level   = count_q;
    assign bus_io.drop_count   = drop_q;

    always_comb begin
        bus_io.cmd_button = 4'b0000;
        if (valid) begin
            case (head[7:0])
                8'h01:   bus_io.cmd_button = 4'b0001;
                8'h02:   bus_io.cmd_button = 4'b0010;
                8'h03:   bus_io.cmd_button = 4'b0100;
                8'h04:   bus_io.cmd_button = 4'b1000;
                default: bus_io.cmd_button = 4'b0000;
            endcase
        end
    end
endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Self-checking bench for ir_cmd_scheduler: frame table, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_ir_cmd_scheduler;
    localparam int unsigned Depth   = 4;
    localparam int unsigned Holdoff = 1000;
    localparam logic [15:0] Custom  = 16'h0000;
    localparam logic [7:0]  MuteKey = 8'h0C;

    logic clk;
    logic rst_n;
    ir_cmd_scheduler_if #(.Depth(Depth)) bus ();

    ir_cmd_scheduler #(
        .Depth        (Depth),
        .HoldoffCycles(Holdoff),
        .CustomCode   (Custom),
        .CheckCustom  (1'b1),
        .MuteKey      (MuteKey)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pop_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference model: a command queue plus one in-flight IR frame that spends one
    // cycle being judged and then waits for a free FIFO slot.
    logic [8:0]  m_q[$];
    bit          m_prev, m_busy, m_judged, m_mute;
    logic [31:0] m_frame;
    logic [7:0]  m_last;
    int          m_hold, m_drops;

    function automatic void model_reset();
        m_q.delete();
        m_prev = 0; m_busy = 0; m_judged = 0; m_mute = 0;
        m_frame = '0; m_last = '0; m_hold = 0; m_drops = 0;
    endfunction

    function automatic logic [3:0] btn(input logic [7:0] k);
        return (k >= 8'd1 && k <= 8'd4) ? 4'(1 << (k - 1)) : 4'b0000;
    endfunction

    function automatic void model_edge(input bit iv, input logic [31:0] id, input bit mr,
                                       input logic [7:0] mk, input bit rdy);
        bit pop, room, busy_old, man_w;
        int drops, hold_n;
        logic [7:0] key;
        pop      = (m_q.size() > 0) && rdy;
        room     = (m_q.size() < Depth) || pop;
        busy_old = m_busy;
        drops    = 0;
        man_w    = 0;
        hold_n   = (m_hold > 0) ? m_hold - 1 : 0;
        key      = m_frame[23:16];
        if (pop) void'(m_q.pop_front());
        if (mr) begin
            if (room) begin
                m_q.push_back({1'b1, mk});
                man_w = 1;
                if (mk == MuteKey) m_mute = !m_mute;
            end else drops++;
        end
        if (m_busy && !m_judged) begin
            if (m_frame[31:24] != ~key || m_frame[15:0] != Custom) m_busy = 0;
            else if (key == m_last && m_hold != 0) begin
                hold_n = Holdoff;
                m_busy = 0;
            end else m_judged = 1;
        end else if (m_busy && room && !man_w) begin
            m_q.push_back({1'b0, key});
            if (key == MuteKey) m_mute = !m_mute;
            m_last = key;
            hold_n = Holdoff;
            m_busy = 0;
        end
        if (iv && !m_prev) begin
            if (busy_old) drops++;
            else begin
                m_busy = 1; m_judged = 0; m_frame = id;
            end
        end
        m_hold  = hold_n;
        m_prev  = iv;
        m_drops = (m_drops + drops > 255) ? 255 : m_drops + drops;
    endfunction

    task automatic check_model();
        logic [7:0] k;
        k = (m_q.size() > 0) ? m_q[0][7:0] : 8'h00;
        chk("mdl_cmd_valid", bus.cmd_valid, m_q.size() > 0);
        chk("mdl_cmd_key", bus.cmd_key, k);
        chk("mdl_cmd_src", bus.cmd_src, (m_q.size() > 0) ? m_q[0][8] : 1'b0);
        chk("mdl_cmd_button", bus.cmd_button, btn(k));
        chk("mdl_mute", bus.mute, m_mute);
        chk("mdl_fifo_level", bus.fifo_level, m_q.size());
        chk("mdl_drop_count", bus.drop_count, m_drops);
    endtask

    task automatic step();
        bit iv, mr, rdy;
        logic [31:0] id;
        logic [7:0] mk;
        iv = bus.ir_valid; id = bus.ir_data; mr = bus.man_req; mk = bus.man_key;
        rdy = bus.cmd_ready;
        if (bus.cmd_valid && rdy) pop_cnt++;
        @(posedge clk);
        model_edge(iv, id, mr, mk, rdy);
        #1;
        check_model();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_frame(input logic [31:0] d);
        bus.ir_data  = d;
        bus.ir_valid = 1'b1;
        steps(3);
        bus.ir_valid = 1'b0;
        step();
    endtask

    task automatic do_reset();
        bus.ir_valid = 1'b0;
        bus.man_req  = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst_cmd_valid", bus.cmd_valid, 0);
        chk("rst_cmd_key", bus.cmd_key, 0);
        chk("rst_cmd_button", bus.cmd_button, 0);
        chk("rst_mute", bus.mute, 0);
        chk("rst_fifo_level", bus.fifo_level, 0);
        chk("rst_drop_count", bus.drop_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] data;
        bit          accept;
        logic [7:0]  key;
        logic [3:0]  button;
    } vec_t;

    vec_t vecs[10];
    logic [7:0] keys[7];

    initial begin
        vecs[0] = '{32'hFE01_0000, 1, 8'h01, 4'b0001};
        vecs[1] = '{32'hFF01_0000, 0, 8'h00, 4'b0000};
        vecs[2] = '{32'hFD02_0000, 1, 8'h02, 4'b0010};
        vecs[3] = '{32'hFD02_6B86, 0, 8'h00, 4'b0000};
        vecs[4] = '{32'hFB04_0000, 1, 8'h04, 4'b1000};
        vecs[5] = '{32'hF30C_0000, 1, 8'h0C, 4'b0000};
        vecs[6] = '{32'hFC03_0000, 1, 8'h03, 4'b0100};
        vecs[7] = '{32'h00FF_0000, 1, 8'hFF, 4'b0000};
        vecs[8] = '{32'hFE01_1234, 0, 8'h00, 4'b0000};
        vecs[9] = '{32'h01FE_0000, 1, 8'hFE, 4'b0000};
        keys = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0C, 8'h55};

        rst_n = 1'b1;
        bus.ir_valid = 0; bus.ir_data = '0; bus.man_req = 0; bus.man_key = '0;
        bus.cmd_ready = 1;
        #1;
        do_reset();

        // Frame table: latency, decode and rejection with the consumer always ready.
        foreach (vecs[i]) begin
            bus.ir_data  = vecs[i].data;
            bus.ir_valid = 1'b1;
            step();
            chk("tbl_lat_e0", bus.cmd_valid, 0);
            step();
            chk("tbl_lat_e1", bus.cmd_valid, 0);
            step();
            chk("tbl_valid", bus.cmd_valid, vecs[i].accept);
            if (vecs[i].accept) begin
                chk("tbl_key", bus.cmd_key, vecs[i].key);
                chk("tbl_src", bus.cmd_src, 0);
                chk("tbl_button", bus.cmd_button, vecs[i].button);
            end
            bus.ir_valid = 1'b0;
            step();
            chk("tbl_pulse_end", bus.cmd_valid, 0);
            chk("tbl_drops", bus.drop_count, 0);
            steps(2);
        end

        // Holdoff: repeat suppressed, suppression reloads the window, then expiry.
        do_reset();
        pop_cnt = 0;
        send_frame(32'hFE01_0000);
        steps(96);
        send_frame(32'hFE01_0000);
        steps(950);
        send_frame(32'hFE01_0000);
        steps(4);
        chk("holdoff_suppressed", pop_cnt, 1);
        steps(1200);
        send_frame(32'hFE01_0000);
        steps(4);
        chk("holdoff_expired", pop_cnt, 2);

        // Manual request wins against a pending IR frame; mute follows writes.
        do_reset();
        bus.cmd_ready = 0;
        bus.ir_data   = 32'hFD02_0000;
        bus.ir_valid  = 1'b1;
        steps(2);
        bus.man_req = 1'b1;
        bus.man_key = 8'h0C;
        step();
        bus.man_req = 1'b0;
        step();
        bus.ir_valid = 1'b0;
        chk("arb_level", bus.fifo_level, 2);
        chk("arb_mute_on", bus.mute, 1);
        chk("arb_head_key", bus.cmd_key, 8'h0C);
        chk("arb_head_src", bus.cmd_src, 1);
        bus.cmd_ready = 1;
        step();
        chk("arb_second_key", bus.cmd_key, 8'h02);
        chk("arb_second_src", bus.cmd_src, 0);
        chk("arb_second_btn", bus.cmd_button, 4'b0010);
        bus.man_req = 1'b1;
        step();
        bus.man_req = 1'b0;
        chk("arb_mute_off", bus.mute, 0);
        steps(3);

        // Full FIFO: overflow drop, push+pop at full, then drop saturation.
        do_reset();
        bus.cmd_ready = 0;
        bus.man_req   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.man_key = 8'h10 + 8'(i);
            step();
        end
        chk("full_level", bus.fifo_level, 4);
        chk("full_drops", bus.drop_count, 1);
        bus.cmd_ready = 1;
        for (int i = 0; i < 6; i++) begin
            bus.man_key = 8'h20 + 8'(i);
            step();
            chk("full_pushpop_level", bus.fifo_level, 4);
        end
        bus.cmd_ready = 0;
        steps(300);
        chk("drop_saturate", bus.drop_count, 255);
        bus.man_req = 1'b0;

        // Asynchronous reset with a pending frame and a full FIFO.
        do_reset();
        bus.cmd_ready = 0;
        bus.man_req   = 1'b1;
        steps(4);
        bus.man_req = 1'b0;
        send_frame(32'hFE01_0000);
        bus.ir_data  = 32'hFD02_0000;
        bus.ir_valid = 1'b1;
        step();
        bus.ir_valid = 1'b0;
        step();
        chk("pre_rst_drops", bus.drop_count, 1);
        do_reset();
        bus.cmd_ready = 1;
        bus.ir_data   = 32'hFE01_0000;
        bus.ir_valid  = 1'b1;
        steps(3);
        chk("post_rst_valid", bus.cmd_valid, 1);
        chk("post_rst_key", bus.cmd_key, 8'h01);
        bus.ir_valid = 1'b0;
        steps(3);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bus.cmd_ready = ($urandom_range(0, 3) != 0);
            bus.man_req   = ($urandom_range(0, 7) == 0);
            bus.man_key   = keys[$urandom_range(0, 6)];
            if (bus.ir_valid) begin
                if ($urandom_range(0, 1) == 0) bus.ir_valid = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                logic [7:0] k;
                k = keys[$urandom_range(0, 6)];
                bus.ir_data[23:16] = k;
                bus.ir_data[31:24] = ($urandom_range(0, 7) == 0) ? k : ~k;
                bus.ir_data[15:0]  = ($urandom_range(0, 7) == 0) ? 16'(c) : Custom;
                bus.ir_valid = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
